// File: rtl/instr_encoder_loader_if.sv
// Request bundle between a program source and the instruction encoder/loader.
// master drives field-level requests; slave returns ready.
interface instr_encoder_loader_if;
    logic        valid;
    logic        ready;
    logic        last;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [25:0] imm;

    modport master (output valid, last, op, rd, rn, rm, imm, input ready);
    modport slave  (input valid, last, op, rd, rn, rm, imm, output ready);
endinterface

// File: rtl/instr_encoder_loader.sv
// Boot loader: encodes LEGv8 field requests, buffers them, writes sequential imem words.
// Optional ENC_RANGE_CHECK_EN rejects immediates that do not fit their field.
module instr_encoder_loader #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    instr_encoder_loader_if.slave req,
    output logic                  o_imem_we,
    output logic [ADDR_W-1:0]     o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    input  logic                  i_imem_ready,
    output logic                  o_cpu_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_fifo [DEPTH];
    logic [AW:0]       r_wptr, r_rptr;
    logic [AW:0]       w_occ;
    logic              w_empty, w_full, w_accept, w_push, w_pop, w_legal, w_start;
    logic [31:0]       w_enc;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;

    assign w_occ   = r_wptr - r_rptr;
    assign w_empty = (w_occ == '0);
    assign w_full  = (w_occ == (AW+1)'(DEPTH));

    assign req.ready = (r_state == S_LOAD) && !w_full;
    assign w_accept  = req.valid && req.ready;
    assign w_push    = w_accept && w_legal;
    assign w_start   = i_start && (r_state == S_IDLE || r_state == S_DONE);

    assign o_imem_we    = !w_empty && (r_state == S_LOAD || r_state == S_DRAIN);
    assign w_pop        = o_imem_we && i_imem_ready;
    // Gate with we so the bus reads zero whenever no word is on offer.
    assign o_imem_wdata = o_imem_we ? r_fifo[r_rptr[AW-1:0]] : '0;
    assign o_imem_addr  = r_addr;
    assign o_count      = r_count;
    assign o_err        = r_err;
    assign o_cpu_hold   = (r_state != S_DONE);
    assign o_busy       = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign o_done       = (r_state == S_DONE);

    always_comb begin
        w_enc   = '0;
        w_legal = 1'b1;
        case (req.op)
            4'd0: w_enc = {10'b1001000100, req.imm[11:0], req.rn, req.rd};
            4'd1: w_enc = {11'b10101011000, req.rm, 6'b0, req.rn, req.rd};
            4'd2: w_enc = {11'b11101011000, req.rm, 6'b0, req.rn, req.rd};
            4'd3: w_enc = {6'b000101, req.imm};
            4'd4: w_enc = {6'b100101, req.imm};
            4'd5: w_enc = {8'b01010100, req.imm[18:0], 5'b01011};
            4'd6: w_enc = {8'b10110100, req.imm[18:0], req.rd};
            4'd7: w_enc = {11'b11010110000, 5'b11111, 6'b0, req.rn, 5'b0};
            4'd8: w_enc = {11'b11111000010, req.imm[8:0], 2'b00, req.rn, req.rd};
            4'd9: w_enc = {11'b11111000000, req.imm[8:0], 2'b00, req.rn, req.rd};
            default: w_legal = 1'b0;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        // A signed value fits N bits when all bits above N-1 copy the sign.
        case (req.op)
            4'd0:       if (req.imm[25:12] != '0) w_legal = 1'b0;
            4'd5, 4'd6: if (req.imm[25:18] != {8{req.imm[25]}}) w_legal = 1'b0;
            4'd8, 4'd9: if (req.imm[25:8] != {18{req.imm[25]}}) w_legal = 1'b0;
            default: ;
        endcase
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_accept && req.last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_empty || (w_pop && w_occ == (AW+1)'(1))) w_state_nxt = S_DONE;
            S_DONE:  if (i_start) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wptr[AW-1:0]] <= w_enc;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_start) begin
                r_addr  <= i_base_addr;
                r_count <= '0;
                r_err   <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_addr  <= r_addr + ADDR_W'(4);
                    r_count <= r_count + 1'b1;
                end
                if (w_accept && !w_legal) r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: driver pushes expected writes, monitor pops on each imem write.
module tb_instr_encoder_loader;
    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] base = '0;
    logic        imem_ready = 1'b0;
    logic        we, cpu_hold, busy, done, err;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [15:0] count;
    int          rdy_mode = 0;  // 0 low, 1 high, 2 random

    instr_encoder_loader_if rif ();

    instr_encoder_loader #(.DEPTH(4), .ADDR_W(64), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_base_addr(base),
        .req(rif),
        .o_imem_we(we), .o_imem_addr(addr), .o_imem_wdata(wdata),
        .i_imem_ready(imem_ready),
        .o_cpu_hold(cpu_hold), .o_busy(busy), .o_done(done),
        .o_count(count), .o_err(err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    wr_t         sbq[$];
    logic [63:0] m_addr;
    int          m_words;
    bit          m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit ref_legal(input int op, input int imm);
        if (op > 9) return 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        if (op == 0 && (imm < 0 || imm > 4095)) return 1'b0;
        if ((op == 5 || op == 6) && (imm < -262144 || imm > 262143)) return 1'b0;
        if ((op == 8 || op == 9) && (imm < -256 || imm > 255)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_enc(input int op, input int rd, input int rn,
                                            input int rm, input int imm);
        logic [31:0] u;
        logic [31:0] r;
        u = imm;
        case (op)
            0: r = 32'h91000000 + ((u & 32'hFFF) << 10) + rn * 32 + rd;
            1: r = 32'hAB000000 + rm * 65536 + rn * 32 + rd;
            2: r = 32'hEB000000 + rm * 65536 + rn * 32 + rd;
            3: r = 32'h14000000 + (u & 32'h3FFFFFF);
            4: r = 32'h94000000 + (u & 32'h3FFFFFF);
            5: r = 32'h54000000 + ((u & 32'h7FFFF) << 5) + 11;
            6: r = 32'hB4000000 + ((u & 32'h7FFFF) << 5) + rd;
            7: r = 32'hD61F0000 + rn * 32;
            8: r = 32'hF8400000 + ((u & 32'h1FF) << 12) + rn * 32 + rd;
            default: r = 32'hF8000000 + ((u & 32'h1FF) << 12) + rn * 32 + rd;
        endcase
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        imem_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    end

    initial forever begin
        wr_t e;
        @(negedge clk);
        if (!rst && we && imem_ready) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, expected none", addr, wdata);
            end else begin
                e = sbq.pop_front();
                chk("imem_addr", addr, e.addr);
                chk("imem_wdata", 64'(wdata), 64'(e.data));
            end
        end
    end

    task automatic do_start(input logic [63:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = b;
        m_addr = b;
        m_words = 0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input int op, input int rd, input int rn, input int rm, input int imm,
                        input bit last, input int tmo, output bit acc);
        wr_t e;
        rif.valid = 1'b1;
        rif.last  = last;
        rif.op    = op[3:0];
        rif.rd    = rd[4:0];
        rif.rn    = rn[4:0];
        rif.rm    = rm[4:0];
        rif.imm   = imm[25:0];
        acc = 1'b0;
        for (int c = 0; c < tmo; c++) begin
            @(negedge clk);
            if (rif.ready) begin
                @(posedge clk);
                acc = 1'b1;
                break;
            end
        end
        if (acc) begin
            if (ref_legal(op, imm)) begin
                e.addr = m_addr;
                e.data = ref_enc(op, rd, rn, rm, imm);
                sbq.push_back(e);
                m_addr += 64'd4;
                m_words++;
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
        rif.valid = 1'b0;
        rif.last  = 1'b0;
    endtask

    task automatic send_ok(input int op, input int rd, input int rn, input int rm, input int imm,
                           input bit last);
        bit acc;
        send(op, rd, rn, rm, imm, last, 200, acc);
        chk("req_accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) $display("FAIL %s: done never rose within 300 cycles", name);
        chk({name, "_done"}, 64'(seen), 64'd1);
        chk({name, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_count"}, 64'(count), 64'(m_words[15:0]));
        chk({name, "_err"}, 64'(err), 64'(m_err));
        chk({name, "_sb_empty"}, 64'(sbq.size()), 64'd0);
    endtask

    function automatic int rand_imm();
        int v;
        case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 4095));
            1: v = int'($urandom_range(0, 511)) - 256;
            2: v = int'($urandom_range(0, 524287)) - 262144;
            default: begin
                v = int'($urandom & 32'h3FFFFFF);
                if (v >= 33554432) v -= 67108864;
            end
        endcase
        return v;
    endfunction

    initial begin
        bit acc;
        int n_acc;
        rif.valid = 1'b0; rif.last = 1'b0; rif.op = '0;
        rif.rd = '0; rif.rn = '0; rif.rm = '0; rif.imm = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_addr", addr, 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_ready", 64'(rif.ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);

        // Single ADDI X1,X2,#5
        rdy_mode = 1;
        do_start(64'd0);
        send_ok(0, 1, 2, 0, 5, 1'b1);
        wait_done("addi");

        // SUBS then BR
        do_start(64'h1000);
        send_ok(2, 3, 1, 2, 0, 1'b0);
        send_ok(7, 0, 30, 0, 0, 1'b1);
        wait_done("subs_br");

        // B.LT, CBZ, LDUR
        do_start(64'h2000);
        send_ok(5, 0, 0, 0, -2, 1'b0);
        send_ok(6, 7, 0, 0, 3, 1'b0);
        send_ok(8, 4, 5, 0, 8, 1'b1);
        wait_done("branch_ld");

        // Back-pressure: FIFO of 4 with memory stalled
        rdy_mode = 0;
        do_start(64'h3000);
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(0, i, i + 1, 0, i * 3, 1'b0, 4, acc);
            n_acc += int'(acc);
        end
        chk("full_accepted", 64'(n_acc), 64'd4);
        @(negedge clk);
        chk("full_ready", 64'(rif.ready), 64'd0);
        chk("full_we", 64'(we), 64'd1);
        rdy_mode = 1;
        send_ok(9, 6, 7, 0, -4, 1'b1);
        wait_done("backpressure");

        // Illegal op between legal ones
        do_start(64'h4000);
        send_ok(1, 2, 3, 4, 0, 1'b0);
        send_ok(12, 0, 0, 0, 0, 1'b0);
        send_ok(3, 0, 0, 0, 100, 1'b1);
        wait_done("illegal");
        chk("illegal_err", 64'(err), 64'd1);
        chk("illegal_count", 64'(count), 64'd2);

        // ADDI immediate one past the 12-bit field
        do_start(64'h5000);
        send_ok(0, 1, 2, 0, 4096, 1'b1);
        wait_done("addi_4096");

        // Reset mid-load with words queued
        rdy_mode = 0;
        do_start(64'h6000);
        for (int i = 0; i < 3; i++) send_ok(4, 0, 0, 0, i + 1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("midrst_we", 64'(we), 64'd0);
        chk("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_addr", addr, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode = 1;
        do_start(64'hFFFF_FFFF_FFFF_FFF8);
        send_ok(0, 9, 10, 0, 77, 1'b0);
        send_ok(1, 11, 12, 13, 0, 1'b0);
        send_ok(2, 14, 15, 16, 0, 1'b1);
        wait_done("reload_wrap");

        // Randomized loads with random memory stalls
        rdy_mode = 2;
        for (int l = 0; l < 8; l++) begin
            int n = int'($urandom_range(4, 14));
            do_start({$urandom, $urandom} & ~64'd3);
            for (int k = 0; k < n; k++) begin
                int op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15))
                                                     : int'($urandom_range(0, 9));
                send_ok(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 31)), rand_imm(), k == n - 1);
            end
            wait_done("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

- Boot-time program loader for the pipelined LEGv8 core.
- Accepts field-level instruction requests over a valid/ready port and encodes each into a 32-bit machine word.
- Buffers encoded words in a small FIFO and writes them to sequential instruction-memory addresses.
- Holds the CPU in reset until the whole program is written; it is the encoding counterpart of the core's opcode decoder.

## Interface
- DEPTH, 4: FIFO entries (power of 2, ≥2).
- ADDR_W, 64: instruction-memory byte-address width.
- CNT_W, 16: width of the written-word counter.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle pulse; begins a load.
- base_addr  in  ADDR_W  first write address; captured on start.
- req_valid / req_ready  in/out  1  request handshake.
- req_last  in  1  marks the final request of the program.
- req_op  in  4  operation select: 0 ADDI, 1 ADDS, 2 SUBS, 3 B, 4 BL, 5 B.LT, 6 CBZ, 7 BR, 8 LDUR, 9 STUR; 10–15 illegal.
- req_rd, req_rn, req_rm  in  5 each  register fields (Rd/Rt, Rn, Rm).
- req_imm  in  26  signed immediate/offset in instruction words.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded instruction.
- imem_ready  in  1  memory accepts the write this cycle.
- cpu_hold  out  1  core reset request.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  high in DONE.
- count  out  CNT_W  words written since start.
- err  out  1  sticky flag: illegal op or rejected immediate.

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE→LOAD on start.
  - LOAD→DRAIN when a request with req_last=1 is accepted.
  - DRAIN→DONE when the FIFO is empty.
  - DONE→LOAD on start.
  - start is ignored in LOAD and DRAIN.
- On start: capture base_addr into the address register; clear count and err; assert cpu_hold.
- req_ready = (state==LOAD) && FIFO not full. A pop in the same cycle does not raise ready.
- Encoding (bit ranges of the instruction word):
  - ADDI: [31:22]=1001000100, [21:10]=imm[11:0], [9:5]=Rn, [4:0]=Rd.
  - ADDS/SUBS: [31:21]=10101011000 / 11101011000, [20:16]=Rm, [15:10]=0, Rn, Rd.
  - B/BL: [31:26]=000101 / 100101, [25:0]=imm.
  - B.LT: [31:24]=01010100, [23:5]=imm[18:0], [4:0]=01011.
  - CBZ: [31:24]=10110100, [23:5]=imm[18:0], [4:0]=Rt.
  - BR: [31:21]=11010110000, [20:16]=11111, [15:10]=0, Rn, [4:0]=0.
  - LDUR/STUR: [31:21]=11111000010 / 11111000000, [20:12]=imm[8:0], [11:10]=00, Rn, Rt.
- Illegal op: the handshake completes, nothing is enqueued, err is set, count is unchanged. If req_last is also set, the FSM still moves to DRAIN.
- Write: imem_we = FIFO non-empty and state is LOAD or DRAIN.
  - On imem_we && imem_ready: pop, imem_addr += 4 (wraps modulo 2^ADDR_W), count += 1 (wraps).
  - imem_addr and imem_wdata hold stable while imem_ready is low.
- cpu_hold is deasserted only in DONE.

## Timing
- Reset values:
  - state=IDLE, FIFO empty, cpu_hold=1.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - req_ready=0, busy=0, done=0, count=0, err=0.
- Latency: request accepted at edge N → earliest imem_we at cycle N+1. Throughput is one word per cycle with imem_ready=1.
- Simultaneous push and pop with the FIFO full: the pop completes and the push is not accepted (ready was low).
- Reset mid-load: immediate return to the reset values; FIFO contents are discarded.
- done rises the cycle after the final pop; cpu_hold falls the same cycle.

## Configuration
- ENC_RANGE_CHECK_EN defined: immediates outside these ranges are rejected (err set, not enqueued, same rule as an illegal op):
  - ADDI [0,4095]
  - B.LT/CBZ [-2^18, 2^18-1]
  - LDUR/STUR [-256, 255]
- Not defined: immediates are silently truncated to their field width; err reflects illegal ops only.

## Test plan
- start with base 0; ADDI X1,X2,#5 (last) → addr 0 data 0x91001441; then done=1, cpu_hold=0, count=1.
- SUBS X3,X1,X2, then BR X30 → 0xEB020023 at base, 0xD61F03C0 at base+4.
- B.LT imm=-2; CBZ X7 imm=3; LDUR X4,[X5,#8] → 0x54FFFFCB, 0xB4000067, 0xF84080A4.
- imem_ready held low, 6 requests offered with DEPTH=4 → exactly 4 accepted, req_ready=0; release imem_ready → remaining words written in order, addresses +4 each.
- req_op=12 between two valid ops → err=1, count=2, no address gap. ADDI imm=4096 → rejected with the macro; data 0x91000000|fields without it.
- reset asserted in LOAD with 3 words queued → next cycle imem_we=0, cpu_hold=1, state IDLE; a subsequent start reloads from the new base_addr.
